// File: rtl/ysyx_210544_cmt_queue.sv
// Commit queue between writeback and the difftest/trace sink: buffers retired
// records, counts retired/skipped instructions, detects trap and no-commit hang.
module ysyx_210544_cmt_queue #(
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned XLEN        = 64,
  parameter int unsigned WDOG_CYCLES = 4096,
  parameter logic [31:0] TRAP_INST   = 32'h0000006b
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_valid,
  output logic                         o_ready,
  input  logic [4:0]                   i_rd,
  input  logic                         i_rd_wen,
  input  logic [XLEN-1:0]              i_rd_wdata,
  input  logic [XLEN-1:0]              i_pc,
  input  logic [31:0]                  i_inst,
  input  logic                         i_skip,
  input  logic [XLEN-1:0]              i_a0,
  output logic                         o_valid,
  input  logic                         i_ready,
  output logic [4:0]                   o_rd,
  output logic                         o_rd_wen,
  output logic [XLEN-1:0]              o_rd_wdata,
  output logic [XLEN-1:0]              o_pc,
  output logic [31:0]                  o_inst,
  output logic                         o_skip,
  output logic [63:0]                  o_instret,
  output logic [63:0]                  o_skipcnt,
  output logic [$clog2(DEPTH):0]       o_count,
  output logic                         o_halted,
  output logic                         o_pass,
  output logic                         o_timeout
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned WW = $clog2(WDOG_CYCLES);
  localparam logic [CW-1:0] FULL     = CW'(DEPTH);
  localparam logic [WW-1:0] WDOG_MAX = WW'(WDOG_CYCLES - 1);

  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

  typedef struct packed {
    logic [4:0]      rd;
    logic            rd_wen;
    logic [XLEN-1:0] rd_wdata;
    logic [XLEN-1:0] pc;
    logic [31:0]     inst;
    logic            skip;
  } rec_t;

  rec_t            mem [DEPTH];
  rec_t            rec_in;
  rec_t            head;
  state_t          state, state_nxt;
  logic [AW-1:0]   rptr, wptr;
  logic [CW-1:0]   count;
  logic [WW-1:0]   wdog;
  logic [XLEN-1:0] trap_a0;
  logic            pass_q, timeout_q;
  logic            push, pop, trap_push, trap_pop, wdog_fire;

  assign rec_in = '{rd: i_rd, rd_wen: i_rd_wen, rd_wdata: i_rd_wdata,
                    pc: i_pc, inst: i_inst, skip: i_skip};
  assign head   = mem[rptr];

  assign o_count   = count;
  assign o_valid   = (count != '0);
  assign o_ready   = (state == RUN) && (count != FULL);
  assign push      = i_valid & o_ready;
  assign pop       = o_valid & i_ready;
  assign trap_push = push && (i_inst == TRAP_INST);
  // Nothing is accepted after the trap, so in DRAIN the last entry is the trap.
  assign trap_pop  = (state == DRAIN) && pop && (count == CW'(1));
  assign wdog_fire = (state == RUN) && !push && (wdog == WDOG_MAX);

  always_ff @(posedge clk) begin
    if (rst) state <= RUN;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUN: begin
        if (trap_push)      state_nxt = DRAIN;
        else if (wdog_fire) state_nxt = HALTED;
      end
      DRAIN:   if (trap_pop) state_nxt = HALTED;
      default: state_nxt = HALTED;
    endcase
  end

  always_comb begin
    o_rd       = '0;
    o_rd_wen   = 1'b0;
    o_rd_wdata = '0;
    o_pc       = '0;
    o_inst     = '0;
    o_skip     = 1'b0;
    if (o_valid) begin
      o_rd       = head.rd;
      o_rd_wen   = head.rd_wen;
      o_rd_wdata = head.rd_wdata;
      o_pc       = head.pc;
      o_inst     = head.inst;
      o_skip     = head.skip;
    end
    o_halted  = (state == HALTED);
    o_pass    = pass_q;
    o_timeout = timeout_q;
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= rec_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rptr      <= '0;
      wptr      <= '0;
      count     <= '0;
      wdog      <= '0;
      trap_a0   <= '0;
      pass_q    <= 1'b0;
      timeout_q <= 1'b0;
      o_instret <= '0;
      o_skipcnt <= '0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (pop) begin
        if (head.skip) o_skipcnt <= o_skipcnt + 64'd1;
        else           o_instret <= o_instret + 64'd1;
      end
      if (state == RUN) begin
        if (push)                 wdog <= '0;
        else if (wdog != WDOG_MAX) wdog <= wdog + WW'(1);
      end
      if (trap_push) trap_a0 <= i_a0;
      if (trap_pop) begin
        pass_q    <= (trap_a0 == '0);
        timeout_q <= 1'b0;
      end else if (wdog_fire) begin
        pass_q    <= 1'b0;
        timeout_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ysyx_210544_cmt_queue.sv
// Scoreboard bench for the commit queue: accepted records are queued as
// expectations and a negedge monitor checks every popped head record.
module tb_ysyx_210544_cmt_queue;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned XLEN  = 64;
  localparam int unsigned WDOG  = 16;
  localparam logic [31:0] TRAP  = 32'h0000006b;

  typedef struct packed {
    logic [4:0]  rd;
    logic        wen;
    logic [63:0] wdata;
    logic [63:0] pc;
    logic [31:0] inst;
    logic        skip;
  } rec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_valid = 1'b0, i_ready = 1'b0;
  logic [4:0]  i_rd = '0;
  logic        i_rd_wen = 1'b0, i_skip = 1'b0;
  logic [63:0] i_rd_wdata = '0, i_pc = '0, i_a0 = '0;
  logic [31:0] i_inst = '0;
  logic        o_ready, o_valid, o_rd_wen, o_skip, o_halted, o_pass, o_timeout;
  logic [4:0]  o_rd;
  logic [63:0] o_rd_wdata, o_pc, o_instret, o_skipcnt;
  logic [31:0] o_inst;
  logic [3:0]  o_count;

  rec_t exp_q [$];
  int   n_checks = 0;
  int   n_fail   = 0;

  ysyx_210544_cmt_queue #(
    .DEPTH(DEPTH), .XLEN(XLEN), .WDOG_CYCLES(WDOG), .TRAP_INST(TRAP)
  ) dut (
    .clk(clk), .rst(rst),
    .i_valid(i_valid), .o_ready(o_ready),
    .i_rd(i_rd), .i_rd_wen(i_rd_wen), .i_rd_wdata(i_rd_wdata),
    .i_pc(i_pc), .i_inst(i_inst), .i_skip(i_skip), .i_a0(i_a0),
    .o_valid(o_valid), .i_ready(i_ready),
    .o_rd(o_rd), .o_rd_wen(o_rd_wen), .o_rd_wdata(o_rd_wdata),
    .o_pc(o_pc), .o_inst(o_inst), .o_skip(o_skip),
    .o_instret(o_instret), .o_skipcnt(o_skipcnt), .o_count(o_count),
    .o_halted(o_halted), .o_pass(o_pass), .o_timeout(o_timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every pop the DUT performs must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && o_valid && i_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pop", 64'd1, 64'd0);
      end else begin
        rec_t e;
        e = exp_q.pop_front();
        check("pop_pc", o_pc, e.pc);
        check("pop_wdata", o_rd_wdata, e.wdata);
        check("pop_fields", {26'd0, o_rd, o_rd_wen, o_inst, o_skip},
              {26'd0, e.rd, e.wen, e.inst, e.skip});
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    i_valid = 1'b0;
    cyc();
    rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic offer(input logic [4:0] rd, input logic [63:0] wdata, input logic [63:0] pc,
                       input logic [31:0] inst, input logic skip, input logic [63:0] a0,
                       output bit accepted);
    rec_t r;
    i_rd = rd; i_rd_wen = rd[0]; i_rd_wdata = wdata; i_pc = pc;
    i_inst = inst; i_skip = skip; i_a0 = a0; i_valid = 1'b1;
    @(negedge clk);
    accepted = o_ready;
    if (accepted) begin
      r = '{rd: rd, wen: rd[0], wdata: wdata, pc: pc, inst: inst, skip: skip};
      exp_q.push_back(r);
    end
    cyc();
    i_valid = 1'b0;
  endtask

  task automatic wait_halt(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (o_halted) break;
      cyc();
    end
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    bit acc;
    int nacc;

    // reset state
    cyc();
    do_reset();
    check("rst_ready", o_ready, 1);
    check("rst_valid", o_valid, 0);
    check("rst_count", o_count, 0);
    check("rst_pc", o_pc, 0);
    check("rst_cnts", o_instret | o_skipcnt, 0);
    check("rst_flags", {o_halted, o_pass, o_timeout}, 0);

    // streaming: each record visible one cycle after its push
    i_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      offer(5'(k), 64'(k * 3), 64'h1000 + 64'(k * 4), 32'h00000013, 1'b0, '0, acc);
      check("stream_valid", o_valid, 1);
      check("stream_head_pc", o_pc, 64'h1000 + 64'(k * 4));
      check("stream_count", o_count, 1);
    end
    cyc();
    check("stream_instret", o_instret, 20);
    check("stream_empty", o_count, 0);
    check("stream_sb_empty", exp_q.size(), 0);

    // fill to full, then drain and wrap the pointers
    do_reset();
    i_ready = 1'b0;
    nacc = 0;
    for (int k = 0; k < 10; k++) begin
      offer(5'(k + 1), 64'hA000 + 64'(k), 64'h2000 + 64'(k * 4), 32'h00100093, 1'b0, '0, acc);
      if (acc) nacc++;
    end
    check("fill_accepted", nacc, 8);
    check("fill_ready", o_ready, 0);
    check("fill_count", o_count, 8);
    i_ready = 1'b1;
    for (int k = 0; k < 8; k++) cyc();
    check("drain_count", o_count, 0);
    for (int k = 0; k < 3; k++)
      offer(5'(k + 20), 64'hB000 + 64'(k), 64'h3000 + 64'(k * 4), 32'h00200113, 1'b0, '0, acc);
    cyc();
    check("wrap_instret", o_instret, 11);
    check("wrap_sb_empty", exp_q.size(), 0);

    // trap with a0 = 0: pass
    do_reset();
    i_ready = 1'b0;
    for (int k = 0; k < 3; k++)
      offer(5'(k + 3), 64'hC000 + 64'(k), 64'h4000 + 64'(k * 4), 32'h00300193, 1'b0, '0, acc);
    offer(5'd10, 64'd0, 64'h400c, TRAP, 1'b0, 64'd0, acc);
    check("trap_ready_drop", o_ready, 0);
    offer(5'd11, 64'd1, 64'h4010, 32'h00000013, 1'b0, '0, acc);
    check("post_trap_reject", acc, 0);
    check("trap_count", o_count, 4);
    i_ready = 1'b1;
    wait_halt(12);
    check("pass_flags", {o_halted, o_pass, o_timeout}, 3'b110);
    check("pass_instret", o_instret, 4);
    check("pass_count", o_count, 0);
    check("pass_sb_empty", exp_q.size(), 0);

    // trap with a0 = 5 and skipped records: fail
    do_reset();
    i_ready = 1'b0;
    offer(5'd1, 64'h11, 64'h5000, 32'h00000013, 1'b1, '0, acc);
    offer(5'd2, 64'h22, 64'h5004, 32'h00000013, 1'b0, '0, acc);
    offer(5'd3, 64'h33, 64'h5008, 32'h00000013, 1'b1, '0, acc);
    offer(5'd10, 64'h0, 64'h500c, TRAP, 1'b0, 64'd5, acc);
    i_ready = 1'b1;
    wait_halt(12);
    check("fail_flags", {o_halted, o_pass, o_timeout}, 3'b100);
    check("fail_skipcnt", o_skipcnt, 2);
    check("fail_instret", o_instret, 2);

    // watchdog from reset: fires on the 16th edge after reset
    do_reset();
    for (int k = 0; k < 15; k++) cyc();
    check("wdog_not_yet", o_halted, 0);
    cyc();
    check("wdog_flags", {o_halted, o_pass, o_timeout}, 3'b101);
    check("wdog_ready", o_ready, 0);

    // a push on cycle 10 restarts the count
    do_reset();
    for (int k = 0; k < 10; k++) cyc();
    offer(5'd4, 64'h44, 64'h6000, 32'h00000013, 1'b0, '0, acc);
    for (int k = 0; k < 15; k++) cyc();
    check("wdog_restart_not_yet", o_halted, 0);
    cyc();
    check("wdog_restart_flags", {o_halted, o_timeout}, 2'b11);

    // entries remain poppable after a timeout
    do_reset();
    i_ready = 1'b0;
    offer(5'd5, 64'h55, 64'h7000, 32'h00000013, 1'b0, '0, acc);
    offer(5'd6, 64'h66, 64'h7004, 32'h00000013, 1'b1, '0, acc);
    wait_halt(40);
    check("to_flags", {o_halted, o_timeout}, 2'b11);
    check("to_count", o_count, 2);
    i_ready = 1'b1;
    cyc();
    cyc();
    check("to_drained", o_count, 0);
    check("to_counters", {o_instret[31:0], o_skipcnt[31:0]}, {32'd1, 32'd1});

    // reset while draining
    do_reset();
    i_ready = 1'b0;
    for (int k = 0; k < 5; k++)
      offer(5'(k + 7), 64'hD000 + 64'(k), 64'h8000 + 64'(k * 4), 32'h00000013, 1'b0, '0, acc);
    offer(5'd10, 64'd0, 64'h8014, TRAP, 1'b0, 64'd0, acc);
    i_ready = 1'b1;
    cyc();
    i_ready = 1'b0;
    check("mid_count", o_count, 5);
    check("mid_instret", o_instret, 1);
    do_reset();
    check("mid_rst_count", o_count, 0);
    check("mid_rst_valid", o_valid, 0);
    check("mid_rst_ready", o_ready, 1);
    check("mid_rst_cnts", o_instret | o_skipcnt, 0);
    check("mid_rst_halted", o_halted, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
